div_dispatch: RTL and testbench

Front-end sequencer for the 10-by-5 non-restoring divider. It queues divide requests in a small FIFO and issues each one to the divider with a `start` pulse. It waits for the divider to finish, then returns quotient, remainder and flags on a valid/ready output port. It is the divider's only client: upstream logic never drives `start` directly.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_dispatch_fifo.sv | 49 ++++
 rtl/div_dispatch.sv | 140 ++++++++++++++
 tb/tb_div_dispatch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and widths for the divider dispatch front-end.
// Holds the dispatch FSM state enum, the request/result structs and the
// default operand widths of the 10-by-5 divider.
package div_pkg;

    localparam int DIV_DW = 10;
    localparam int DIV_VW = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_HOLD
    } div_disp_state_t;

    typedef struct packed {
        logic [DIV_DW-1:0] dividend;
        logic [DIV_VW-1:0] divisor;
    } div_req_t;

    typedef struct packed {
        logic [DIV_VW-1:0] q;
        logic [DIV_VW-1:0] r;
        logic              ov;
        logic              dbz;
    } div_res_t;

endpackage

// File: rtl/div_dispatch_fifo.sv
// div_dispatch_fifo: synchronous request FIFO, DEPTH entries of W bits.
// Ports: push_i/push_dat_i write, pop_i consumes head shown on pop_dat_o,
// full_o/empty_o status. Zero-latency head read; push+pop at full is legal.
module div_dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign pop_dat_o = mem_q[rd_q];

    // A push while full is only taken when the head leaves in the same
    // cycle; the write lands in the slot being vacated.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + {{(AW-1){1'b0}}, 1'b1};
            if (do_pop)  rd_q <= rd_q + {{(AW-1){1'b0}}, 1'b1};
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat_i;
    end

endmodule

// File: rtl/div_dispatch.sv
// div_dispatch: queues divide requests and sequences the divider one at a time.
// Ports: in_* request (valid/ready), div_* divider handshake, out_* result (valid/ready).
// Optional macro DIV_DISPATCH_ZERO_BYPASS_EN answers zero divisors without the divider.
module div_dispatch
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DIV_DW,
    parameter int VW    = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dividend,
    input  logic [VW-1:0] in_divisor,
    output logic          div_start,
    output logic [DW-1:0] div_dividend,
    output logic [VW-1:0] div_divider,
    input  logic          div_ready,
    input  logic [VW-1:0] div_q,
    input  logic [VW-1:0] div_r,
    input  logic          div_ov,
    input  logic          div_dbz,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_q,
    output logic [VW-1:0] out_r,
    output logic          out_ov,
    output logic          out_dbz
);
    localparam int EW = DW + VW;

    div_disp_state_t state_q, state_d;

    logic [EW-1:0] head;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic          load_op, cap_res;
    logic [DW-1:0] opa_q;
    logic [VW-1:0] opb_q, q_q, r_q;
    logic          ov_q, dbz_q;
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
    logic          bypass;
`endif

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    div_dispatch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i ({in_dividend, in_divisor}),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_op  = 1'b0;
        cap_res  = 1'b0;
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
        bypass   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
                    // Zero divisors never touch the divider, so they need not wait for it.
                    if (head[VW-1:0] == '0) begin
                        fifo_pop = 1'b1;
                        bypass   = 1'b1;
                        state_d  = ST_HOLD;
                    end else
`endif
                    if (div_ready) begin
                        fifo_pop = 1'b1;
                        load_op  = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            // Waiting for busy first keeps the stale ready-high of the previous
            // result from being mistaken for completion of this one.
            ST_WAIT_BUSY: if (!div_ready) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (div_ready) begin
                    cap_res = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD:      if (out_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ov_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_op) {opa_q, opb_q} <= head;
            if (cap_res) begin
                q_q   <= div_q;
                r_q   <= div_r;
                ov_q  <= div_ov;
                dbz_q <= div_dbz;
            end
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
            else if (bypass) begin
                q_q   <= '0;
                r_q   <= '0;
                ov_q  <= 1'b0;
                dbz_q <= 1'b1;
            end
`endif
        end
    end

    // Reset masks start combinationally so an abort never launches a divide.
    assign div_start    = (state_q == ST_ISSUE) && !rst;
    assign div_dividend = opa_q;
    assign div_divider  = opb_q;
    assign out_valid    = (state_q == ST_HOLD);
    assign out_q        = q_q;
    assign out_r        = r_q;
    assign out_ov       = ov_q;
    assign out_dbz      = dbz_q;

endmodule

// File: tb/tb_div_dispatch.sv
module tb_div_dispatch;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_dividend;
    logic [4:0] in_divisor;
    logic       div_start;
    logic [9:0] div_dividend;
    logic [4:0] div_divider;
    logic       div_ready;
    logic [4:0] div_q, div_r;
    logic       div_ov, div_dbz;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_q, out_r;
    logic       out_ov, out_dbz;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;

    always #5 clk = ~clk;

    div_dispatch #(.DEPTH(DEPTH), .DW(10), .VW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_start(div_start), .div_dividend(div_dividend), .div_divider(div_divider),
        .div_ready(div_ready), .div_q(div_q), .div_r(div_r),
        .div_ov(div_ov), .div_dbz(div_dbz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_ov(out_ov), .out_dbz(out_dbz)
    );

    // Behavioural stand-in for the 10-by-5 divider: ready drops after start,
    // result appears after a few cycles. Zero divisor -> dbz, q=31, r=dividend[4:0].
    logic       m_busy;
    logic [2:0] m_cnt;
    logic [9:0] m_a;
    logic [4:0] m_b;

    function automatic logic [11:0] div_model(input logic [9:0] a, input logic [4:0] b);
        int quo, rem;
        if (b == 5'd0) return {1'b1, 1'b0, 5'd31, a[4:0]};
        quo = int'(a) / int'(b);
        rem = int'(a) % int'(b);
        return {1'b0, (quo > 31), quo[4:0], rem[4:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_cnt     <= 3'd0;
            div_ready <= 1'b1;
            {div_dbz, div_ov, div_q, div_r} <= '0;
        end else if (!m_busy) begin
            if (div_start) begin
                m_busy    <= 1'b1;
                div_ready <= 1'b0;
                m_a       <= div_dividend;
                m_b       <= div_divider;
                m_cnt     <= 3'd4;
            end
        end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
        end else begin
            m_busy    <= 1'b0;
            div_ready <= 1'b1;
            {div_dbz, div_ov, div_q, div_r} <= div_model(m_a, m_b);
        end
    end

    always @(posedge clk) if (div_start === 1'b1) n_start <= n_start + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [4:0] b);
        bit ok = 1'b0;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic expect_result(input string tag, input logic [4:0] q, input logic [4:0] r,
                                 input logic ov, input logic dbz, input bit check_q);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_valid"}, seen, 1);
        if (seen) begin
            if (check_q) begin
                chk({tag, "_q"}, out_q, q);
                chk({tag, "_r"}, out_r, r);
            end
            chk({tag, "_ov"}, out_ov, ov);
            chk({tag, "_dbz"}, out_dbz, dbz);
            @(negedge clk);
        end
    endtask

    logic [9:0] bp_a [6] = '{10'd50, 10'd70, 10'd90, 10'd110, 10'd130, 10'd150};
    logic [4:0] bp_b [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    logic [4:0] bp_q [6] = '{5'd16, 5'd17, 5'd18, 5'd18, 5'd18, 5'd18};
    logic [4:0] bp_r [6] = '{5'd2, 5'd2, 5'd0, 5'd2, 5'd4, 5'd6};

    initial begin
        int s0;
        int idx;
        int nv;
        int ns;
        bit seen;
        bit saw_ready;
        bit pend;

        rst = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_div_start", div_start, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_flags", {out_ov, out_dbz}, 0);
        chk("rst_div_dividend", div_dividend, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request 26/5 with latency of the start pulse.
        s0 = n_start;
        in_valid = 1'b1; in_dividend = 10'd26; in_divisor = 5'd5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_no_start_t1", div_start, 0);
        @(negedge clk);
        chk("lat_start_t2", div_start, 1);
        chk("lat_opa", div_dividend, 26);
        chk("lat_opb", div_divider, 5);
        @(negedge clk);
        chk("start_one_cycle", div_start, 0);
        chk("opa_stable", div_dividend, 26);
        expect_result("single", 5'd5, 5'd1, 1'b0, 1'b0, 1'b1);
        chk("single_starts", n_start - s0, 1);

        // Queued burst, consecutive pushes.
        s0 = n_start;
        push(10'd22, 5'd3);
        push(10'd54, 5'd7);
        push(10'd214, 5'd14);
        expect_result("burst0", 5'd7, 5'd1, 1'b0, 1'b0, 1'b1);
        expect_result("burst1", 5'd7, 5'd5, 1'b0, 1'b0, 1'b1);
        expect_result("burst2", 5'd15, 5'd4, 1'b0, 1'b0, 1'b1);
        chk("burst_starts", n_start - s0, 3);

        // Overflow.
        push(10'd794, 5'd1);
        expect_result("ovf", 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);

        // Zero divisor.
        s0 = n_start;
        push(10'd26, 5'd0);
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
        expect_result("dbz_bypass", 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("dbz_bypass_starts", n_start - s0, 0);
`else
        expect_result("dbz_pass", 5'd31, 5'd26, 1'b0, 1'b1, 1'b1);
        chk("dbz_pass_starts", n_start - s0, 1);
`endif

        // Backpressure at full: DEPTH+2 requests with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(bp_a[i], bp_b[i]);
        in_valid = 1'b1; in_dividend = bp_a[5]; in_divisor = bp_b[5];
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("bp_hold_valid", seen, 1);
        chk("bp_in_ready_low", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_stable_valid", out_valid, 1);
            chk("bp_stable_q", out_q, bp_q[0]);
            chk("bp_stable_r", out_r, bp_r[0]);
        end
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        idx = 0;
        saw_ready = 1'b0;
        for (int c = 0; c < 400 && idx < 6; c++) begin
            if (out_valid) begin
                chk("bp_drain_q", out_q, bp_q[idx]);
                chk("bp_drain_r", out_r, bp_r[idx]);
                idx++;
            end
            pend = in_valid && in_ready;
            if (pend) saw_ready = 1'b1;
            @(negedge clk);
            if (pend) in_valid = 1'b0;
        end
        chk("bp_drain_count", idx, 6);
        chk("bp_sixth_accepted", saw_ready, 1);

        // Reset while waiting on the divider with two requests queued.
        push(10'd100, 5'd3);
        push(10'd101, 5'd4);
        push(10'd102, 5'd5);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (!div_ready) seen = 1'b1;
            else @(negedge clk);
        end
        chk("mid_busy_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        chk("mid_start_low", div_start, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        s0 = n_start;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        ns = n_start - s0;
        chk("mid_no_stale_result", nv, 0);
        chk("mid_no_stale_start", ns, 0);

        // Block still works after the abort.
        push(10'd26, 5'd5);
        expect_result("post_rst", 5'd5, 5'd1, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
